// File: rtl/reaction_counter_pkg.sv
// Shared definitions for the reaction timer core: state codes, LFSR seed and feedback taps.
package reaction_counter_pkg;

   typedef enum logic [1:0] {
      ST_DONE   = 2'b00,
      ST_IDLE   = 2'b01,
      ST_WAIT   = 2'b10,
      ST_TIMING = 2'b11
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/reaction_counter_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; saturates at 9999 and flags it.
module bcd_counter4 (
   input  logic        clk,
   input  logic        resetn,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [15:0] bcd_o,
   output logic        at_max_o
);

   logic [15:0] bcd_q, bcd_d;
   logic        carry;

   assign at_max_o = (bcd_q == 16'h9999);
   assign bcd_o    = bcd_q;

   always_comb begin
      bcd_d = bcd_q;
      carry = inc_i & ~at_max_o;
      if (clr_i) begin
         bcd_d = '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (bcd_q[4*i +: 4] == 4'd9) begin
                  bcd_d[4*i +: 4] = 4'd0;
               end else begin
                  bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                  carry           = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) bcd_q <= '0;
      else         bcd_q <= bcd_d;
   end

endmodule

// File: rtl/reaction_counter.sv
// Reaction timer game core: random pre-GO delay, then millisecond BCD timing until react.
module reaction_counter
   import reaction_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned RAND_BITS    = 11
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       react,
   output logic [3:0] BCD0,
   output logic [3:0] BCD1,
   output logic [3:0] BCD2,
   output logic [3:0] BCD3,
   output logic [1:0] en,
   output logic       go_led,
   output logic       false_start,
   output logic       timeout
);

   localparam int unsigned TICK_DIV = CLK_HZ / 1000;
   localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   if (MIN_DELAY_MS + (2 ** RAND_BITS) - 1 > 65535) begin : g_bad_delay
      $error("reaction_counter: delay range does not fit 16 bits");
   end

   state_e        state_q, state_d;
   logic          start_q, react_q;
   logic [15:0]   lfsr_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   delay_q, delay_d;
   logic          go_led_q, false_start_q, false_start_d, timeout_q, timeout_d;
   logic          start_edge, react_edge, tick, presc_clr;
   logic          bcd_clr, bcd_inc, at_max;
   logic [15:0]   bcd;

   assign start_edge = start & ~start_q;
   assign react_edge = react & ~react_q;
   assign tick       = (presc_q == TICK_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; a react edge takes priority over any simultaneous tick
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (start_edge) state_d = ST_WAIT;
         ST_WAIT: begin
            if (react_edge)                     state_d = ST_IDLE;
            else if (tick && delay_q <= 16'd1)  state_d = ST_TIMING;
         end
         ST_TIMING: begin
            if (react_edge)            state_d = ST_DONE;
            else if (tick && at_max)   state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      delay_d       = delay_q;
      presc_clr     = 1'b0;
      bcd_clr       = 1'b0;
      bcd_inc       = 1'b0;
      false_start_d = false_start_q;
      timeout_d     = timeout_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_edge) begin
               bcd_clr       = 1'b1;
               presc_clr     = 1'b1;
               false_start_d = 1'b0;
               timeout_d     = 1'b0;
               delay_d       = 16'(MIN_DELAY_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
            end
         end
         ST_WAIT: begin
            if (react_edge) begin
               false_start_d = 1'b1;
            end else if (tick) begin
               delay_d = delay_q - 16'd1;
               if (delay_q <= 16'd1) presc_clr = 1'b1;
            end
         end
         ST_TIMING: begin
            if (!react_edge && tick) begin
               if (at_max) timeout_d = 1'b1;
               else        bcd_inc   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      if (presc_clr || tick) presc_d = '0;
      else                   presc_d = presc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         start_q       <= 1'b0;
         react_q       <= 1'b0;
         lfsr_q        <= LFSR_SEED;
         presc_q       <= '0;
         delay_q       <= '0;
         go_led_q      <= 1'b0;
         false_start_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         start_q       <= start;
         react_q       <= react;
         lfsr_q        <= lfsr_next(lfsr_q);
         presc_q       <= presc_d;
         delay_q       <= delay_d;
         go_led_q      <= (state_d == ST_TIMING);
         false_start_q <= false_start_d;
         timeout_q     <= timeout_d;
      end
   end

   bcd_counter4 u_bcd (
      .clk      (clk),
      .resetn   (resetn),
      .clr_i    (bcd_clr),
      .inc_i    (bcd_inc),
      .bcd_o    (bcd),
      .at_max_o (at_max)
   );

   assign en          = state_q;
   assign go_led      = go_led_q;
   assign false_start = false_start_q;
   assign timeout     = timeout_q;
   assign BCD0        = bcd[3:0];
   assign BCD1        = bcd[7:4];
   assign BCD2        = bcd[11:8];
   assign BCD3        = bcd[15:12];

endmodule

// File: tb/tb_reaction_counter.sv
// Directed bench for reaction_counter: 3 cycles per ms, delay = 2 + lfsr[1:0] ms.
module tb_reaction_counter;

   localparam int TD = 3;

   logic       clk = 1'b0;
   logic       resetn, start, react;
   logic [3:0] BCD0, BCD1, BCD2, BCD3;
   logic [1:0] en;
   logic       go_led, false_start, timeout;
   logic [15:0] bcd;

   int n_total = 0;
   int n_pass  = 0;
   int exp_d;
   int n;

   logic [15:0] m_lfsr;
   logic [15:0] bcd_prev  = 16'h0000;
   logic [15:0] after99   = 16'hFFFF;
   logic [15:0] after999  = 16'hFFFF;
   logic        bad_digit = 1'b0;

   reaction_counter #(
      .CLK_HZ       (3_000),
      .MIN_DELAY_MS (2),
      .RAND_BITS    (2)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .react       (react),
      .BCD0        (BCD0),
      .BCD1        (BCD1),
      .BCD2        (BCD2),
      .BCD3        (BCD3),
      .en          (en),
      .go_led      (go_led),
      .false_start (false_start),
      .timeout     (timeout)
   );

   assign bcd = {BCD3, BCD2, BCD1, BCD0};

   always #5 clk = ~clk;

   // Reference LFSR: Fibonacci, taps 16,14,13,11
   always @(posedge clk) begin
      if (!resetn) m_lfsr <= 16'hACE1;
      else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   always @(negedge clk) begin
      if (bcd_prev == 16'h0099 && bcd != 16'h0099) after99 = bcd;
      if (bcd_prev == 16'h0999 && bcd != 16'h0999) after999 = bcd;
      if (BCD0 > 4'd9 || BCD1 > 4'd9 || BCD2 > 4'd9 || BCD3 > 4'd9) bad_digit = 1'b1;
      bcd_prev = bcd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Raise start (left high) and step past the edge that enters WAIT
   task automatic start_round();
      exp_d = 2 + int'(m_lfsr[1:0]);
      start = 1'b1;
      cyc(1);
      chk("enter_wait", 32'(en), 32'(2'b10));
   endtask

   task automatic wait_go();
      n = 0;
      while (!go_led && n <= 40) begin
         cyc(1);
         n++;
      end
      chk("wait_len", 32'(n), 32'(exp_d * TD));
      chk("go_en", 32'(en), 32'(2'b11));
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; react = 1'b0;
      // 1. reset
      cyc(2);
      chk("rst_en", 32'(en), 32'(2'b01));
      chk("rst_bcd", 32'(bcd), 32'h0000);
      chk("rst_go", 32'(go_led), 32'd0);
      chk("rst_fs", 32'(false_start), 32'd0);
      chk("rst_to", 32'(timeout), 32'd0);
      resetn = 1'b1;
      cyc(3);

      // 2. react 123 ticks after GO; start held high throughout
      start_round();
      wait_go();
      cyc(TD - 1);
      chk("first_tick_early", 32'(bcd), 32'h0000);
      cyc(1);
      chk("first_tick", 32'(bcd), 32'h0001);
      cyc(122 * TD);
      chk("pre_react", 32'(bcd), 32'h0123);
      react = 1'b1;
      cyc(1);
      chk("r123_en", 32'(en), 32'(2'b00));
      chk("r123_bcd", 32'(bcd), 32'h0123);
      chk("r123_go", 32'(go_led), 32'd0);
      cyc(100);
      chk("hold_en", 32'(en), 32'(2'b00));
      chk("hold_bcd", 32'(bcd), 32'h0123);
      start = 1'b0; react = 1'b0;
      cyc(2);

      // 3. false start during WAIT
      start_round();
      chk("new_round_bcd", 32'(bcd), 32'h0000);
      start = 1'b0;
      cyc(2);
      react = 1'b1;
      cyc(1);
      chk("fs_en", 32'(en), 32'(2'b01));
      chk("fs_flag", 32'(false_start), 32'd1);
      chk("fs_bcd", 32'(bcd), 32'h0000);
      cyc(20);
      chk("fs_no_go", 32'(go_led), 32'd0);
      chk("fs_stay_idle", 32'(en), 32'(2'b01));
      react = 1'b0;
      cyc(1);
      // react coincident with delay expiry: false start wins
      start_round();
      chk("fs_cleared", 32'(false_start), 32'd0);
      start = 1'b0;
      cyc(exp_d * TD - 1);
      react = 1'b1;
      cyc(1);
      chk("expiry_react_en", 32'(en), 32'(2'b01));
      chk("expiry_react_fs", 32'(false_start), 32'd1);
      chk("expiry_react_go", 32'(go_led), 32'd0);
      react = 1'b0;
      cyc(1);

      // 5. carry chain, react after 1000 ticks
      start_round();
      start = 1'b0;
      wait_go();
      cyc(1000 * TD);
      chk("k_bcd", 32'(bcd), 32'h1000);
      react = 1'b1;
      cyc(1);
      chk("k_en", 32'(en), 32'(2'b00));
      chk("k_hold", 32'(bcd), 32'h1000);
      chk("after_0099", 32'(after99), 32'h0100);
      chk("after_0999", 32'(after999), 32'h1000);
      react = 1'b0;
      cyc(1);

      // 4. timeout, no react
      start_round();
      start = 1'b0;
      wait_go();
      n = 0;
      while (en != 2'b00 && n <= 10000 * TD + 20) begin
         cyc(1);
         n++;
      end
      chk("to_len", 32'(n), 32'(10000 * TD));
      chk("to_bcd", 32'(bcd), 32'h9999);
      chk("to_flag", 32'(timeout), 32'd1);
      chk("to_go", 32'(go_led), 32'd0);
      cyc(20);
      chk("to_nowrap", 32'(bcd), 32'h9999);
      chk("to_stay", 32'(en), 32'(2'b00));
      chk("digits_ok", 32'(bad_digit), 32'd0);
      start_round();
      chk("to_cleared", 32'(timeout), 32'd0);
      chk("to_bcd_clr", 32'(bcd), 32'h0000);
      start = 1'b0;

      // 6. reset during TIMING, then react on a tick edge
      wait_go();
      cyc(42 * TD);
      chk("pre_rst_bcd", 32'(bcd), 32'h0042);
      resetn = 1'b0;
      cyc(1);
      chk("mid_rst_en", 32'(en), 32'(2'b01));
      chk("mid_rst_bcd", 32'(bcd), 32'h0000);
      chk("mid_rst_go", 32'(go_led), 32'd0);
      resetn = 1'b1;
      cyc(2);
      start_round();
      start = 1'b0;
      wait_go();
      cyc(TD - 1);
      react = 1'b1;
      cyc(1);
      chk("tick_react_en", 32'(en), 32'(2'b00));
      chk("tick_react_bcd", 32'(bcd), 32'h0000);
      react = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
